echo_pulse_meter: RTL
=====================

// Module: echo_pulse_meter
// PURPOSE
//  Parametrised HC-SR04 echo-width meter; successor to the free-running echo counter.
//  - Adds explicit start/arm, an input synchroniser, timeout detection and a one-cycle valid strobe.
//  - Optional auto-rearm and 4-sample averaging.
//  - Sits between the trigger generator and the distance/display logic.
//  - Reports echo high time in clk cycles.
// PARAMETERS
//  WIDTH          16    width of counter and echo_duration
//  TIMEOUT_CYCLES 1000  max cycles waiting for rise, or measuring high time; must be < 2**WIDTH
//  SYNC_STAGES    2     echo synchroniser depth (>=2)
//  AUTO_REARM     0     1: return to ARMED after each result; 0: return to IDLE
// PORTS
//  clk            in   1      system clock
//  rst            in   1      asynchronous reset, active-high
//  start          in   1      arm a measurement (sampled in IDLE only)
//  echo           in   1      raw echo pin, asynchronous
//  busy           out  1      high in ARMED/MEASURE
//  valid          out  1      one-cycle pulse: new echo_duration
//  timeout        out  1      one-cycle pulse: no rise, or pulse too long
//  echo_duration  out  WIDTH  last good pulse width in cycles
//  echo_avg       out  WIDTH  (ECHO_AVG_EN only) mean of last 4 results
//  avg_valid      out  1      (ECHO_AVG_EN only) one-cycle pulse with echo_avg
// BEHAVIOUR
//  - rst=1: all flops 0 immediately; outputs 0; FSM=IDLE; synchroniser cleared.
//  - echo passes SYNC_STAGES flops -> echo_s. Rise/fall edges detected from echo_s vs. its 1-cycle delay.
//  - FSM transitions:
//      IDLE:    start=1 -> ARMED; cnt<=0.
//      ARMED:   cnt++ each cycle.
//               rise -> MEASURE with cnt<=1.
//               cnt==TIMEOUT_CYCLES-1 with no rise -> timeout=1, go to IDLE.
//      MEASURE: cnt++ while echo_s=1.
//               fall -> echo_duration<=cnt, valid=1 next cycle -> IDLE, or ARMED if AUTO_REARM.
//               cnt==TIMEOUT_CYCLES with echo_s still 1 -> timeout=1, echo_duration unchanged -> IDLE.
//                 No ARMED re-entry on this path even when AUTO_REARM=1.
//  - echo_duration = number of cycles echo_s was high. Range 1..TIMEOUT_CYCLES-1.
//  - Latency: pin fall -> valid = SYNC_STAGES+1 cycles.
//  - echo already high when ARMED entered: ignored until a fresh rise (low then high).
//  - start while busy is ignored. start and a rise in the same cycle in IDLE: the rise is ignored.
//  - Rise and timeout in the same ARMED cycle: rise wins.
//  - valid and timeout are never high together. busy drops in the cycle valid/timeout pulses.
//  - Counter never wraps: limited by TIMEOUT_CYCLES.
//  - rst mid-MEASURE: result discarded, no valid/timeout pulse.
// CONFIGURATION
//  - ECHO_AVG_EN defined:
//      4-entry shift register of results (zeros after reset); sum width WIDTH+2.
//      echo_avg = sum>>2 (truncating).
//      avg_valid pulses with valid once 4 results have been collected since reset; echo_avg is 0 until then.
//      Timeouts do not enter the history.
//  - ECHO_AVG_EN undefined: echo_avg/avg_valid ports and logic absent; all else identical.
// TESTING  (WIDTH=16, TIMEOUT_CYCLES=1000, SYNC_STAGES=2, AUTO_REARM=0)
//  1. Reset: assert rst mid-cycle, echo toggling -> all outputs 0 at once; busy=0 after release.
//  2. Basic: start, echo high 100 cycles -> one valid pulse, echo_duration=100, busy=0;
//     valid 3 cycles after pin fall.
//  3. No echo: start, echo low -> timeout pulse exactly 1000 cycles after ARMED entry;
//     echo_duration keeps prior 100.
//  4. Long echo: start, echo held high 1500 cycles -> timeout at cnt=1000, no valid, IDLE.
//  5. Edge cases:
//     - echo already high at start, low 5 cycles, then high 50 -> echo_duration=50.
//     - start pulses while busy -> ignored.
//     - rst after 40 cycles of MEASURE -> no pulse.
//  6. AUTO_REARM=1 with ECHO_AVG_EN: echo widths 100,200,300,400 after one start
//     -> four valids; avg_valid only on the 4th, echo_avg=250.

Source files
------------

// File: rtl/echo_pulse_meter_if.sv
// echo_pulse_meter_if
// Groups the echo meter's control and result signals.
//   master : drives start and the raw echo pin; observes busy/valid/timeout/results
//   slave  : the meter itself
// Signals: start, echo (raw, asynchronous), busy, valid, timeout, echo_duration[WIDTH],
//          and with ECHO_AVG_EN defined: echo_avg[WIDTH], avg_valid.
interface echo_pulse_meter_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             echo;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [WIDTH-1:0] echo_duration;
`ifdef ECHO_AVG_EN
  logic [WIDTH-1:0] echo_avg;
  logic             avg_valid;

  modport master (
    output start, echo,
    input  busy, valid, timeout, echo_duration, echo_avg, avg_valid
  );
  modport slave (
    input  start, echo,
    output busy, valid, timeout, echo_duration, echo_avg, avg_valid
  );
`else
  modport master (
    output start, echo,
    input  busy, valid, timeout, echo_duration
  );
  modport slave (
    input  start, echo,
    output busy, valid, timeout, echo_duration
  );
`endif
endinterface

// File: rtl/echo_pulse_meter.sv
// echo_pulse_meter
// Measures the high time of an HC-SR04 echo pulse in clk cycles. A measurement is
// armed by start (accepted only when idle); the raw echo pin is synchronised, its
// rising edge opens the measurement and its falling edge closes it with a one-cycle
// valid strobe. Missing or over-long echoes end with a one-cycle timeout strobe.
// Optional macro ECHO_AVG_EN adds a running mean of the last four results.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high; clears every flop
//   bus  : echo_pulse_meter_if.slave
//          start, echo -> in ; busy, valid, timeout, echo_duration -> out
//          echo_avg, avg_valid -> out (ECHO_AVG_EN only)
module echo_pulse_meter #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2,
  parameter bit AUTO_REARM     = 1'b0
) (
  input logic               clk,
  input logic               rst,
  echo_pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ARM_LAST = WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] MEAS_MAX = WIDTH'(TIMEOUT_CYCLES);

  state_t                 state;
  logic [WIDTH-1:0]       cnt;
  logic                   busy_q;
  logic                   valid_q;
  logic                   timeout_q;
  logic [WIDTH-1:0]       duration_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   echo_d;
  logic                   echo_s;
  logic                   rise;
  logic                   fall;
  logic                   take;

  assign echo_s = sync_q[SYNC_STAGES-1];
  assign rise   = echo_s & ~echo_d;
  assign fall   = ~echo_s & echo_d;
  // A fall accepted as a result; at the count limit the pulse counts as too long.
  assign take   = (state == MEASURE) && fall && (cnt != MEAS_MAX);

  // Synchroniser plus one-cycle delay for edge detection.
  // NOTE: non-blocking assignments so every flop samples the pre-edge value of the
  // previous stage; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      echo_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.echo};
      echo_d <= echo_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      duration_q <= '0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          // A rise in this same cycle is not seen: edges are only looked at in ARMED.
          if (bus.start) begin
            state  <= ARMED;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        ARMED: begin
          // Rise is tested first so it wins over a timeout in the same cycle.
          if (rise) begin
            state <= MEASURE;
            cnt   <= ONE;
          end else if (cnt == ARM_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        MEASURE: begin
          if (cnt == MEAS_MAX) begin
            // Too long: no result, and never re-armed on this path.
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end else if (take) begin
            duration_q <= cnt;
            valid_q    <= 1'b1;
            if (AUTO_REARM) begin
              state <= ARMED;
              cnt   <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.valid         = valid_q;
  assign bus.timeout       = timeout_q;
  assign bus.echo_duration = duration_q;

`ifdef ECHO_AVG_EN
  logic [WIDTH-1:0] hist [4];
  logic [2:0]       n_res;
  logic             avg_valid_q;
  logic [WIDTH+1:0] hist_sum;

  assign hist_sum = (WIDTH+2)'(hist[0]) + (WIDTH+2)'(hist[1])
                  + (WIDTH+2)'(hist[2]) + (WIDTH+2)'(hist[3]);

  // NOTE: the history is reset like any flop: it is only four words, and the
  // mean must start from a known all-zero window after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      n_res       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (take) begin
        hist[0] <= cnt;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        if (n_res != 3'd4) n_res <= n_res + 3'd1;
        // This result is at least the fourth since reset.
        avg_valid_q <= (n_res >= 3'd3);
      end
    end
  end

  // The window updates on the same edge as avg_valid, so the mean is current with it.
  assign bus.echo_avg  = (n_res == 3'd4) ? WIDTH'(hist_sum >> 2) : '0;
  assign bus.avg_valid = avg_valid_q;
`endif

endmodule
